// File: rtl/board_eval_if.sv
// Bus bundle for board_eval: the HPS-facing register port and the SDRAM-facing master port.
//   slave  modport : the accelerator side (serves slave_*, drives master_* requests)
//   master modport : the system side (HPS drives slave_* requests, SDRAM answers master_*)
// Signals:
//   slave_waitrequest/address/read/readdata/write/writedata : Avalon-MM register port
//   master_waitrequest/address/read/readdata/readdatavalid/write/writedata : Avalon-MM SDRAM port
interface board_eval_if;
   logic        slave_waitrequest;
   logic [3:0]  slave_address;
   logic        slave_read;
   logic [31:0] slave_readdata;
   logic        slave_write;
   logic [31:0] slave_writedata;

   logic        master_waitrequest;
   logic [31:0] master_address;
   logic        master_read;
   logic [31:0] master_readdata;
   logic        master_readdatavalid;
   logic        master_write;
   logic [31:0] master_writedata;

   modport slave (
      output slave_waitrequest, slave_readdata,
      input  slave_address, slave_read, slave_write, slave_writedata,
      input  master_waitrequest, master_readdata, master_readdatavalid,
      output master_address, master_read, master_write, master_writedata
   );

   modport master (
      input  slave_waitrequest, slave_readdata,
      output slave_address, slave_read, slave_write, slave_writedata,
      output master_waitrequest, master_readdata, master_readdatavalid,
      input  master_address, master_read, master_write, master_writedata
   );
endinterface

// File: rtl/board_eval.sv
// board_eval: reads N 64-square boards from SDRAM, computes a signed material score
// per board, writes each score back, and reports the best board index/score.
// Ports:
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   bus   : board_eval_if.slave (register slave port + SDRAM master port)
// Registers: 0 start / best index (stalls while busy), 1 boards_base, 2 num_boards,
//   3 result_base, 4 best_score (RO), 5 best_index (RO), 6 side.
// Optional feature macro: BOARD_EVAL_SIDE_EN (reg 6 side select: 1 = minimum score).
module board_eval (
   input logic       clk,
   input logic       rst_n,
   board_eval_if.slave bus
);
   localparam int unsigned NUM_SQUARES = 64;
   localparam int unsigned MAX_BOARDS  = 255;
   localparam int unsigned SQ_W        = 6;
   localparam int unsigned BRD_W       = 8;
   localparam int unsigned DW          = 32;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      INIT     = 3'd1,
      RD_REQ   = 3'd2,
      RD_WAIT  = 3'd3,
      WR_SCORE = 3'd4,
      NEXT     = 3'd5,
      DONE     = 3'd6
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [DW-1:0]        boards_base;
   logic [DW-1:0]        result_base;
   logic [BRD_W-1:0]     num_boards;
   logic signed [DW-1:0] acc;
   logic [SQ_W-1:0]      sq_cnt;
   logic [BRD_W-1:0]     board_cnt;
   logic signed [DW-1:0] best_score;
   logic [DW-1:0]        best_index;
   logic                 side;

   logic                 m_read;
   logic                 m_write;
   logic [DW-1:0]        m_address;
   logic [DW-1:0]        m_writedata;
   logic [DW-1:0]        rdata;
   logic                 s_wait;

   logic                 cfg_we;
   logic                 start;
   logic                 last_sq;
   logic                 last_board;
   logic                 better;
   logic [7:0]           code;
   logic [DW-1:0]        rd_addr;
   logic [DW-1:0]        wr_addr;

   // Material value of one signed piece code; sign of the code gives the sign of the value.
   function automatic logic signed [31:0] piece_value(input logic [7:0] c);
      logic [7:0]         mag;
      logic signed [31:0] v;
      mag = c[7] ? 8'(8'd0 - c) : c;   // -128 maps to 128, which falls in the zero band
      if (mag >= 8'd1 && mag <= 8'd8)        v = 32'sd100;
      else if (mag >= 8'd9 && mag <= 8'd18)  v = 32'sd500;
      else if (mag >= 8'd19 && mag <= 8'd28) v = 32'sd320;
      else if (mag >= 8'd29 && mag <= 8'd38) v = 32'sd330;
      else if (mag >= 8'd39 && mag <= 8'd47) v = 32'sd900;
      else if (mag == 8'd48)                 v = 32'sd20000;
      else                                   v = 32'sd0;
      return c[7] ? -v : v;
   endfunction

   assign code       = bus.master_readdata[7:0];
   assign cfg_we     = bus.slave_write && (state == IDLE);   // config/start only accepted when idle
   assign start      = cfg_we && (bus.slave_address == 4'd0);
   assign last_sq    = (sq_cnt == SQ_W'(NUM_SQUARES - 1));
   assign last_board = ({1'b0, board_cnt} + 9'd1) == {1'b0, num_boards};
   assign better     = side ? (acc < best_score) : (acc > best_score);
   assign rd_addr    = boards_base + 32'({board_cnt, 8'h00}) + 32'({sq_cnt, 2'b00});
   assign wr_addr    = result_base + 32'({board_cnt, 2'b00});

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (start) state_nxt = INIT;
         INIT:     state_nxt = (num_boards == '0) ? DONE : RD_REQ;
         RD_REQ:   if (!bus.master_waitrequest) state_nxt = RD_WAIT;
         RD_WAIT:  if (bus.master_readdatavalid) state_nxt = last_sq ? WR_SCORE : RD_REQ;
         WR_SCORE: if (!bus.master_waitrequest) state_nxt = NEXT;
         NEXT:     state_nxt = last_board ? DONE : RD_REQ;
         DONE:     state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   // Master port outputs decoded from state; address/data come from registers so they hold while stalled
   always_comb begin
      m_read      = 1'b0;
      m_write     = 1'b0;
      m_address   = '0;
      m_writedata = '0;
      case (state)
         RD_REQ: begin
            m_read    = 1'b1;
            m_address = rd_addr;
         end
         WR_SCORE: begin
            m_write     = 1'b1;
            m_address   = wr_addr;
            m_writedata = acc;
         end
         default: ;
      endcase
   end

   // Datapath and register file
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         boards_base <= '0;
         result_base <= '0;
         num_boards  <= '0;
         acc         <= '0;
         sq_cnt      <= '0;
         board_cnt   <= '0;
         best_score  <= 32'sh8000_0000;
         best_index  <= 32'hFFFF_FFFF;
      end else begin
         if (cfg_we) begin
            case (bus.slave_address)
               4'd1: boards_base <= bus.slave_writedata;
               4'd2: num_boards  <= (bus.slave_writedata > 32'(MAX_BOARDS)) ?
                                    BRD_W'(MAX_BOARDS) : bus.slave_writedata[7:0];
               4'd3: result_base <= bus.slave_writedata;
               default: ;
            endcase
         end
         if (start) begin
            best_index <= 32'hFFFF_FFFF;
            best_score <= side ? 32'sh7FFF_FFFF : 32'sh8000_0000;
         end
         case (state)
            INIT: begin
               acc       <= '0;
               sq_cnt    <= '0;
               board_cnt <= '0;
            end
            RD_WAIT: begin
               if (bus.master_readdatavalid) begin
                  acc    <= acc + piece_value(code);
                  sq_cnt <= sq_cnt + SQ_W'(1);   // wraps to 0 after the last square
               end
            end
            WR_SCORE: begin
               // strict compare: ties keep the earlier board
               if (!bus.master_waitrequest && better) begin
                  best_score <= acc;
                  best_index <= 32'(board_cnt);
               end
            end
            NEXT: begin
               board_cnt <= board_cnt + BRD_W'(1);
               acc       <= '0;
            end
            default: ;
         endcase
      end
   end

`ifdef BOARD_EVAL_SIDE_EN
   // Side select register
   always_ff @(posedge clk) begin
      if (!rst_n)                                    side <= 1'b0;
      else if (cfg_we && bus.slave_address == 4'd6) side <= bus.slave_writedata[0];
   end
`else
   assign side = 1'b0;
`endif

   // Register read mux; reg 0 holds off via waitrequest until the run completes
   assign s_wait = bus.slave_read && (bus.slave_address == 4'd0) && (state != IDLE);

   always_comb begin
      rdata = '0;
      if (bus.slave_read && !s_wait) begin
         case (bus.slave_address)
            4'd0: rdata = best_index;
            4'd1: rdata = boards_base;
            4'd2: rdata = 32'(num_boards);
            4'd3: rdata = result_base;
            4'd4: rdata = best_score;
            4'd5: rdata = best_index;
            4'd6: rdata = 32'(side);
            default: rdata = '0;
         endcase
      end
   end

   assign bus.slave_waitrequest = s_wait;
   assign bus.slave_readdata    = rdata;
   assign bus.master_read       = m_read;
   assign bus.master_write      = m_write;
   assign bus.master_address    = m_address;
   assign bus.master_writedata  = m_writedata;
endmodule

// File: tb/tb_board_eval.sv
// Self-checking bench for board_eval: SDRAM model with programmable stall,
// score-write scoreboard, directed register-level scenarios.
module tb_board_eval;
   localparam logic [31:0] BB = 32'h0000_0400;
   localparam logic [31:0] RB = 32'h0000_2000;

   logic clk;
   logic rst_n;
   board_eval_if bus();

   board_eval dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
   } wr_t;
   wr_t exp_q[$];

   // SDRAM model
   logic [31:0] mem [0:4095];
   int          stall = 0;
   int          wcnt = 0;
   int          rd_cnt = 0;
   int          wr_cnt = 0;
   logic        rvalid_q = 1'b0;
   logic [31:0] rdata_q = '0;
   logic [31:0] last_addr = '0;

   assign bus.master_waitrequest   = (bus.master_read || bus.master_write) && (wcnt < stall);
   assign bus.master_readdatavalid = rvalid_q;
   assign bus.master_readdata      = rdata_q;

   always @(posedge clk) begin
      wr_t e;
      rvalid_q <= 1'b0;
      if (!rst_n) begin
         wcnt <= 0;
      end else if (bus.master_read || bus.master_write) begin
         if (wcnt > 0) begin
            tests++;
            assert (bus.master_address === last_addr) else begin
               fails++;
               $error("FAIL addr_stable: observed %h expected %h", bus.master_address, last_addr);
            end
         end
         last_addr <= bus.master_address;
         if (wcnt < stall) begin
            wcnt <= wcnt + 1;
         end else begin
            wcnt <= 0;
            if (bus.master_read) begin
               rd_cnt++;
               rvalid_q <= 1'b1;
               rdata_q  <= mem[bus.master_address[13:2]];
            end
            if (bus.master_write) begin
               wr_cnt++;
               tests++;
               assert (exp_q.size() != 0) else begin
                  fails++;
                  $error("FAIL unexpected_write: observed addr %h data %h expected none",
                         bus.master_address, bus.master_writedata);
               end
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  tests++;
                  assert ({bus.master_address, bus.master_writedata} === {e.a, e.d}) else begin
                     fails++;
                     $error("FAIL score_write: observed %h/%h expected %h/%h",
                            bus.master_address, bus.master_writedata, e.a, e.d);
                  end
               end
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.slave_address   = a;
      bus.slave_writedata = d;
      bus.slave_write     = 1'b1;
      @(negedge clk);
      bus.slave_write     = 1'b0;
   endtask

   task automatic rd(input logic [3:0] a, output logic [31:0] d, output int cyc);
      @(negedge clk);
      bus.slave_address = a;
      bus.slave_read    = 1'b1;
      cyc = 0;
      #1;
      while (bus.slave_waitrequest && cyc < 5000) begin
         @(negedge clk);
         #1;
         cyc++;
      end
      tests++;
      assert (cyc < 5000) else begin
         fails++;
         $error("FAIL read_timeout: observed %0d cycles expected < 5000", cyc);
      end
      d = bus.slave_readdata;
      @(negedge clk);
      bus.slave_read = 1'b0;
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 4096; i++) mem[i] = 32'h1234_5600;
   endtask

   task automatic place(input int b, input int s, input logic [7:0] c);
      logic [31:0] a;
      a = BB + 32'(b * 256) + 32'(s * 4);
      mem[a[13:2]] = {24'hC0FFEE, c};
   endtask

   task automatic setup(input logic [31:0] n);
      wr(4'd1, BB);
      wr(4'd2, n);
      wr(4'd3, RB);
      wr(4'd0, 32'd0);
   endtask

   // Boards scoring 100, 900, 900
   task automatic fill_three();
      clear_mem();
      place(0, 0, 8'd5);
      place(0, 20, 8'd20);
      place(0, 21, 8'hEC);   // -20
      place(1, 0, 8'd48);
      place(1, 10, 8'd40);
      place(1, 63, 8'hD0);   // -48
      place(2, 0, 8'd10);
      place(2, 1, 8'd2);
      place(2, 2, 8'd3);
      place(2, 3, 8'd4);
      place(2, 4, 8'd8);
      place(2, 5, 8'd30);
      place(2, 6, 8'hE2);    // -30
      place(2, 7, 8'd49);
      place(2, 8, 8'h80);    // -128
   endtask

   task automatic push_three();
      exp_q.push_back('{RB,              32'd100});
      exp_q.push_back('{RB + 32'd4,      32'd900});
      exp_q.push_back('{RB + 32'd8,      32'd900});
   endtask

   task automatic run_three(input string tag);
      logic [31:0] d;
      int          cyc;
      push_three();
      setup(32'd3);
      rd(4'd0, d, cyc);
      chk({tag, "_best_index"}, d, 32'd1);
      rd(4'd4, d, cyc);
      chk({tag, "_best_score"}, d, 32'd900);
      chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      logic [31:0] d;
      int          cyc;
      int          r0;
      int          w0;
      int          guard;

      rst_n = 1'b0;
      bus.slave_address   = '0;
      bus.slave_read      = 1'b0;
      bus.slave_write     = 1'b0;
      bus.slave_writedata = '0;
      clear_mem();
      repeat (3) @(negedge clk);

      chk("rst_master_read",  32'(bus.master_read), 32'd0);
      chk("rst_master_write", 32'(bus.master_write), 32'd0);
      chk("rst_master_addr",  bus.master_address, 32'd0);
      chk("rst_slave_wait",   32'(bus.slave_waitrequest), 32'd0);
      chk("rst_slave_rdata",  bus.slave_readdata, 32'd0);
      rst_n = 1'b1;
      rd(4'd5, d, cyc);
      chk("rst_best_index", d, 32'hFFFF_FFFF);
      rd(4'd4, d, cyc);
      chk("rst_best_score", d, 32'h8000_0000);
      rd(4'd6, d, cyc);
      chk("rst_side", d, 32'd0);

      // Single board: +1 and -1 cancel
      clear_mem();
      place(0, 8, 8'd1);
      place(0, 48, 8'hFF);
      exp_q.push_back('{RB, 32'd0});
      setup(32'd1);
      rd(4'd0, d, cyc);
      chk("b1_best_index", d, 32'd0);
      chk("b1_latency_ok", 32'(cyc <= 133), 32'd1);
      rd(4'd4, d, cyc);
      chk("b1_best_score", d, 32'd0);
      chk("b1_queue_empty", 32'(exp_q.size()), 32'd0);

      // Single board: queen vs enemy king
      clear_mem();
      place(0, 3, 8'd39);
      place(0, 60, 8'hD0);
      exp_q.push_back('{RB, 32'hFFFF_B564});
      setup(32'd1);
      rd(4'd0, d, cyc);
      chk("b2_best_index", d, 32'd0);
      rd(4'd4, d, cyc);
      chk("b2_best_score", d, 32'hFFFF_B564);
      chk("b2_queue_empty", 32'(exp_q.size()), 32'd0);

      // Three boards with a tie on the maximum
      fill_three();
      run_three("three");
      rd(4'd1, d, cyc);
      chk("reg_boards_base", d, BB);
      rd(4'd2, d, cyc);
      chk("reg_num_boards", d, 32'd3);
      rd(4'd3, d, cyc);
      chk("reg_result_base", d, RB);

      // Zero boards: no traffic, fast completion
      r0 = rd_cnt;
      w0 = wr_cnt;
      wr(4'd2, 32'd0);
      wr(4'd0, 32'd0);
      rd(4'd0, d, cyc);
      chk("zero_best_index", d, 32'hFFFF_FFFF);
      chk("zero_fast", 32'(cyc <= 4), 32'd1);
      chk("zero_no_reads", 32'(rd_cnt - r0), 32'd0);
      chk("zero_no_writes", 32'(wr_cnt - w0), 32'd0);
      rd(4'd4, d, cyc);
      chk("zero_best_score", d, 32'h8000_0000);

      // SDRAM stalls on every request
      stall = 3;
      run_three("stall");
      stall = 0;

      // Reset in the middle of board 1
      push_three();
      r0 = rd_cnt;
      setup(32'd3);
      guard = 0;
      while ((rd_cnt - r0) < 84 && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      chk("mid_reached", 32'(guard < 2000), 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_read_low",  32'(bus.master_read), 32'd0);
      chk("mid_write_low", 32'(bus.master_write), 32'd0);
      rst_n = 1'b1;
      chk("mid_one_written", 32'(exp_q.size()), 32'd2);
      exp_q.delete();
      w0 = wr_cnt;
      repeat (300) @(negedge clk);
      chk("mid_no_write", 32'(wr_cnt - w0), 32'd0);
      rd(4'd5, d, cyc);
      chk("mid_best_index", d, 32'hFFFF_FFFF);
      rd(4'd1, d, cyc);
      chk("mid_base_cleared", d, 32'd0);
      run_three("restart");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/board_eval.md
Name: board_eval

Overview:
- Avalon-MM accelerator directly downstream of the pawn/piece move generators.
- Reads N candidate boards that a generator wrote to SDRAM and computes a signed material score for each board.
- Writes each score back to SDRAM and reports the best board index and score to the HPS through its slave port.
- Same slave/master register style as the move generators, so software drives both identically.

Parameters:
- NUM_SQUARES, 64, squares per board.
- MAX_BOARDS, 255, largest legal board count.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- slave_waitrequest  out  1  stall for slave read of reg 0 while busy
- slave_address  in  4  register select
- slave_read  in  1  slave read strobe
- slave_readdata  out  32  register read data
- slave_write  in  1  slave write strobe
- slave_writedata  in  32  register write data
- master_waitrequest  in  1  SDRAM stall
- master_address  out  32  SDRAM byte address
- master_read  out  1  master read request
- master_readdata  in  32  read data; bits [7:0] hold the signed piece code
- master_readdatavalid  in  1  read data valid
- master_write  out  1  master write request
- master_writedata  out  32  score write data

Behaviour:
- Clock and reset: single clock clk; reset rst_n is synchronous, active-low.
- Board layout: square i is at base + 4*i, one word per square (generator output format). Board k starts at boards_base + 256*k.
- Registers:
  - 0: write = start (data ignored). Read = stall until done, then return best index.
  - 1: boards_base.
  - 2: num_boards; only low 8 bits are used, values above MAX_BOARDS saturate.
  - 3: result_base; score k is written at result_base + 4*k.
  - 4: read-only, best_score.
  - 5: read-only, best_index.
- Piece values, by |code|:
  - 1-8 → 100
  - 9-18 → 500
  - 19-28 → 320
  - 29-38 → 330
  - 39-47 → 900
  - 48 → 20000
  - 0 or above 48 → 0
  - Positive codes add; negative codes subtract. Accumulation is signed 32-bit and never saturates.
- Reset: all outputs 0, state IDLE, registers cleared, best_index = 0xFFFFFFFF, best_score = 0x80000000.
- FSM states and transitions:
  - IDLE → INIT on write to reg 0.
  - INIT: clear the accumulator, square counter and board counter. If num_boards == 0 → DONE with no master traffic.
  - RD_REQ: assert master_read and hold master_address until master_waitrequest is low, then → RD_WAIT.
  - RD_WAIT: on master_readdatavalid, add the piece value; square counter +1. Counter 63 → WR_SCORE, else → RD_REQ. Only one read outstanding at a time.
  - WR_SCORE: assert master_write with the accumulator until master_waitrequest is low. Update best if score > best_score (strict compare, so ties keep the lower index). → NEXT.
  - NEXT: board counter +1. Last board → DONE, else clear the accumulator → RD_REQ.
  - DONE: → IDLE after one cycle.
- Start handling: best_index and best_score are re-initialised on every start. Writes to regs 0-3 while busy are ignored and never stall.
- slave_waitrequest: combinational. High only when slave_read && address == 0 && state != IDLE. Reg 0 read data is valid in the cycle waitrequest drops.
- Latency with zero-wait SDRAM and readdatavalid one cycle after accept: at most 2*64 + 3 cycles per board, plus 2 cycles of overhead.
- Reset mid-operation: master_read and master_write fall at the next edge. The outstanding read's data is discarded and no partial score is written.

Optional Feature:
- Macro BOARD_EVAL_SIDE_EN.
- Defined: adds reg 6 "side", reset 0. side = 1 selects the minimum score (best_score resets to 0x7FFFFFFF at start; compare is strict <). side = 0 selects the maximum.
- Undefined: reg 6 reads 0 and writes are ignored; selection is always maximum.

Test Plan:
- One board, all squares empty except code 1 at square 8 and code -1 at square 48 → score word 0 at result_base, best_index 0, best_score 0.
- One board, code 39 at square 3 and code -48 at square 60 → score −19100 (0xFFFFB564) written.
- Three boards scoring 100, 900, 900 → words written at result_base+0/4/8, best_index 1 (tie keeps the lower index), best_score 900.
- num_boards = 0 → reg 0 read completes within 4 cycles, no master_read or master_write seen, best_index 0xFFFFFFFF.
- master_waitrequest held 3 cycles on every request, with the three-board case → identical results; master_address stable while stalled.
- rst_n low for one cycle mid-board-1 → master strobes low next cycle, no score write follows. A restart then produces correct results.
